hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the bubble request that drives the main controller's Controller_Write input, plus PC, IF/ID write enables and stage flushes.
- Detects load-use hazards in ID against a load in EX, and flushes on branches resolved in MEM (BEQ/BNE).
- Holds a small FSM for stall/flush sequencing and saturating performance counters readable by the FPGA debug logic.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the 5-stage MIPS core control logic.
package mips_pkg;

    // Branch field encodings carried in EX/MEM.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BEQ  = 2'b11;

    // Primary opcode values.
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Hazard controller sequencing states.
    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_FLUSH_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count qualifying cycles; hold once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline.
// Outputs are combinational from registered state plus current inputs so a
// stall or flush acts in the cycle the condition is seen.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int FLUSH_HOLD = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [1:0]       mem_branch,
    input  logic             mem_zero,
    output logic             ctrl_bubble,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbg_state
);

    // Wait cycles after the flush cycle itself; the FLUSH_WAIT state is left
    // on the cycle that observes hold==0, giving FLUSH_HOLD wait cycles.
    localparam logic [3:0] HOLD_INIT = (FLUSH_HOLD > 0) ? 4'(FLUSH_HOLD - 1) : 4'd0;

    hz_state_t  state;
    logic [3:0] hold;
    logic       taken;
    logic       lu_hazard;
    logic       decide;
    logic       stall_inc;
    logic       flush_inc;

    assign taken = ((mem_branch == BR_BEQ) &&  mem_zero) ||
                   ((mem_branch == BR_BNE) && !mem_zero);

    // $zero is never a real producer, so it cannot cause a stall.
    assign lu_hazard = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // RUN and LOAD_STALL make the same decision; FLUSH_WAIT ignores inputs.
    assign decide    = (state != HZ_FLUSH_WAIT);
    assign stall_inc = decide && !taken && lu_hazard;
    assign flush_inc = decide && taken;
    assign dbg_state = state;

    // State and flush hold sequencing; taken beats a load-use hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HZ_RUN;
            hold  <= 4'd0;
        end else begin
            case (state)
                HZ_RUN, HZ_LOAD_STALL: begin
                    if (taken) begin
                        if (FLUSH_HOLD > 0) begin
                            state <= HZ_FLUSH_WAIT;
                            hold  <= HOLD_INIT;
                        end else begin
                            state <= HZ_RUN;
                        end
                    end else if (lu_hazard) begin
                        state <= HZ_LOAD_STALL;
                    end else begin
                        state <= HZ_RUN;
                    end
                end
                HZ_FLUSH_WAIT: begin
                    if (hold == 4'd0) begin
                        state <= HZ_RUN;
                    end else begin
                        hold <= hold - 4'd1;
                    end
                end
                default: begin
                    state <= HZ_RUN;
                    hold  <= 4'd0;
                end
            endcase
        end
    end

    // Pipeline control: reset forces a full freeze, otherwise state decides.
    always_comb begin
        ctrl_bubble = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (reset) begin
            ctrl_bubble = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (state == HZ_FLUSH_WAIT) begin
            ctrl_bubble = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            flush_ifid  = 1'b1;
        end else if (taken) begin
            ctrl_bubble = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (lu_hazard) begin
            ctrl_bubble = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end
    end

    // EX/MEM was flushed on entry to FLUSH_WAIT, so no branch can resolve there.
    always_ff @(posedge clk) begin
        if (!reset && (state == HZ_FLUSH_WAIT)) begin
            assert (!taken);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (1'b0),
        .inc   (stall_inc),
        .value (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (1'b0),
        .inc   (flush_inc),
        .value (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (FLUSH_HOLD=3/CNT_W=4 and
// FLUSH_HOLD=0/CNT_W=16) on shared inputs, checked against a cycle model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, mem_zero;
    logic [1:0] mem_branch;

    logic        a_bub, a_pcw, a_ifw, a_fif, a_fid, a_fex;
    logic [3:0]  a_stall, a_flush;
    logic [1:0]  a_dbg;
    logic        b_bub, b_pcw, b_ifw, b_fif, b_fid, b_fex;
    logic [15:0] b_stall, b_flush;
    logic [1:0]  b_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: remaining flush-wait cycles and event counts.
    int wait_a = 0;
    int stall_a = 0, flush_a = 0, stall_b = 0, flush_b = 0;

    // Clock generation.
    always #5 clk = ~clk;

    hazard_unit #(.FLUSH_HOLD(3), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .ctrl_bubble(a_bub), .pc_write(a_pcw), .ifid_write(a_ifw),
        .flush_ifid(a_fif), .flush_idex(a_fid), .flush_exmem(a_fex),
        .stall_count(a_stall), .flush_count(a_flush), .dbg_state(a_dbg)
    );

    hazard_unit #(.FLUSH_HOLD(0), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .ctrl_bubble(b_bub), .pc_write(b_pcw), .ifid_write(b_ifw),
        .flush_ifid(b_fif), .flush_idex(b_fid), .flush_exmem(b_fex),
        .stall_count(b_stall), .flush_count(b_flush), .dbg_state(b_dbg)
    );

    function automatic bit m_taken();
        return (mem_branch == 2'b11 && mem_zero) || (mem_branch == 2'b01 && !mem_zero);
    endfunction

    function automatic bit m_hazard();
        return ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    // Expected {bubble, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem}.
    function automatic logic [5:0] m_ctl(input int wait_left);
        if (reset)              return 6'b100_111;
        else if (wait_left > 0) return 6'b100_100;
        else if (m_taken())     return 6'b111_111;
        else if (m_hazard())    return 6'b100_000;
        else                    return 6'b011_000;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ctl_a", {26'd0, a_bub, a_pcw, a_ifw, a_fif, a_fid, a_fex}, {26'd0, m_ctl(wait_a)});
        chk("ctl_b", {26'd0, b_bub, b_pcw, b_ifw, b_fif, b_fid, b_fex}, {26'd0, m_ctl(0)});
        chk("stall_a", {28'd0, a_stall}, stall_a);
        chk("flush_a", {28'd0, a_flush}, flush_a);
        chk("stall_b", {16'd0, b_stall}, stall_b);
        chk("flush_b", {16'd0, b_flush}, flush_b);
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        if (reset) begin
            wait_a = 0; stall_a = 0; flush_a = 0; stall_b = 0; flush_b = 0;
        end else begin
            if (wait_a > 0) begin
                wait_a--;
            end else if (m_taken()) begin
                flush_a = sat_inc(flush_a, 15);
                wait_a  = 3;
            end else if (m_hazard()) begin
                stall_a = sat_inc(stall_a, 15);
            end
            if (m_taken())       flush_b = sat_inc(flush_b, 65535);
            else if (m_hazard()) stall_b = sat_inc(stall_b, 65535);
        end
    endtask

    // Driver: apply inputs mid-cycle, check before the edge, then step model.
    task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic mr, input logic [4:0] ert,
                         input logic [1:0] br, input logic z);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_rt = ut;
        ex_mem_read = mr; ex_rt = ert; mem_branch = br; mem_zero = z;
        #2;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_rt = 0; mem_branch = 2'b00; mem_zero = 0;
        #3;
        check_all();                               // forced outputs under reset
        @(posedge clk); model_edge();
        @(negedge clk); reset = 1'b0;

        cycle(0, 0, 0, 0, 0, 2'b00, 0);            // idle defaults
        cycle(2, 7, 0, 1, 2, 2'b00, 0);            // LW $2 then use of rs=$2
        cycle(2, 7, 0, 0, 2, 2'b00, 0);            // bubble in EX: defaults
        chk("stall_one", {28'd0, a_stall}, 32'd1);
        cycle(0, 0, 1, 1, 0, 2'b00, 0);            // $zero never hazards
        cycle(1, 5, 0, 1, 5, 2'b00, 0);            // rt match but rt not read
        cycle(1, 5, 1, 1, 5, 2'b00, 0);            // rt read: stall
        cycle(3, 3, 1, 1, 3, 2'b11, 1);            // BEQ taken beats hazard
        cycle(0, 0, 0, 0, 0, 2'b00, 0);            // wait cycles on instance a
        cycle(0, 0, 0, 1, 4, 2'b00, 0);
        cycle(4, 0, 0, 1, 4, 2'b00, 0);            // hazard ignored while waiting
        chk("flush_one", {16'd0, b_flush}, 32'd1);
        cycle(4, 0, 0, 1, 4, 2'b11, 0);            // BEQ not taken: stall only
        cycle(0, 0, 0, 0, 0, 2'b01, 0);            // BNE taken, hold 3
        for (int i = 0; i < 3; i++) cycle(6, 6, 1, 1, 6, 2'b00, 0);
        cycle(0, 0, 0, 0, 0, 2'b00, 0);            // back in RUN
        cycle(0, 0, 0, 0, 0, 2'b01, 1);            // BNE not taken
        for (int i = 0; i < 20; i++) cycle(2, 0, 0, 1, 2, 2'b00, 0);
        chk("stall_sat", {28'd0, a_stall}, 32'd15);
        cycle(0, 0, 0, 0, 0, 2'b11, 1);            // enter flush wait
        cycle(0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        reset = 1'b1;                               // async reset mid-wait
        #1;
        wait_a = 0; stall_a = 0; flush_a = 0; stall_b = 0; flush_b = 0;
        check_all();
        chk("rst_stall", {28'd0, a_stall}, 32'd0);
        @(posedge clk); model_edge();
        @(negedge clk); reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 2'b00, 0);            // RUN defaults after reset

        // Random traffic over a small register range for frequent collisions.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] br;
            logic [1:0] pick;
            pick = 2'($urandom_range(0, 3));
            br = (pick == 2'd2) ? 2'b10 : pick;
            if ($urandom_range(0, 2) != 0) br = 2'b00;
            if (wait_a > 0) br = 2'b00;
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), br, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
